// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTL). Stage k applies a shift of 2^k when
// bit k of the shift amount is set; each stage has its own valid bit, and stalls do not propagate past an empty stage.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready are both 1.
// in_ready depends only on the stage valid bits and out_ready (no dependence on in_valid).
// out_valid and data_result come straight from the last stage and stay stable while out_ready is 0.
module pipelined_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]         ctrl_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result
);

    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;
    localparam logic [1:0] MODE_ROTL = 2'b11;

    // The MSB is never altered by an arithmetic right shift, so every SRA step
    // fills with the original operand's sign bit.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       mode,
                                                    input int               amt);
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_SLL:  r = d << amt;
            MODE_SRL:  r = d >> amt;
            MODE_SRA:  r = $signed(d) >>> amt;
            MODE_ROTL: r = (d << amt) | (d >> (WIDTH - amt));
            default:   r = d;
        endcase
        return r;
    endfunction

    logic [SHAMT_W-1:0] stg_valid;
    logic [WIDTH-1:0]   stg_data [SHAMT_W];
    logic [SHAMT_W-1:0] adv;

    // Stage k may load unless it and every stage downstream are full while out_ready is low.
    always_comb begin
        logic all_full;
        adv      = '0;
        all_full = 1'b1;
        for (int k = SHAMT_W - 1; k >= 0; k--) begin
            all_full = all_full & stg_valid[k];
            adv[k]   = out_ready | ~all_full;
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic                 v_q;
        logic [WIDTH-1:0]     d_q;
        logic                 src_v;
        logic [WIDTH-1:0]     src_d;
        logic [SHAMT_W-k-1:0] src_amt;
        logic [1:0]           src_mode;

        if (k == 0) begin : g_src
            assign src_v    = in_valid;
            assign src_d    = data_operandA;
            assign src_amt  = ctrl_shiftamt;
            assign src_mode = ctrl_mode;
        end else begin : g_src
            assign src_v    = stg_valid[k-1];
            assign src_d    = stg_data[k-1];
            assign src_amt  = g_stage[k-1].g_ctl.amt_q;
            assign src_mode = g_stage[k-1].g_ctl.mode_q;
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (adv[k]) begin
                v_q <= src_v;
                d_q <= src_amt[0] ? shift_step(src_d, src_mode, 1 << k) : src_d;
            end
        end

        // Only the not-yet-applied amount bits travel on; bit 0 is always the next one to apply.
        if (k < SHAMT_W - 1) begin : g_ctl
            logic [SHAMT_W-k-2:0] amt_q;
            logic [1:0]           mode_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    amt_q  <= '0;
                    mode_q <= '0;
                end else if (adv[k]) begin
                    amt_q  <= src_amt[SHAMT_W-k-1:1];
                    mode_q <= src_mode;
                end
            end
        end

        assign stg_valid[k] = v_q;
        assign stg_data[k]  = d_q;
    end

    assign in_ready    = adv[0];
    assign out_valid   = stg_valid[SHAMT_W-1];
    assign data_result = stg_data[SHAMT_W-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed literal cases, streaming, backpressure,
// mid-stream reset and random traffic, all checked every cycle against a shift/queue model.
module tb_pipelined_shifter;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   data_operandA = '0;
    logic [SHAMT_W-1:0] ctrl_shiftamt = '0;
    logic [1:0]         ctrl_mode = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   data_result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               acc_q[$];
    int               last_stall = -1;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    pipelined_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .ctrl_mode     (ctrl_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a,
                                                   input int unsigned amt,
                                                   input logic [1:0] mode);
        logic signed [WIDTH-1:0] sa;
        sa = a;
        case (mode)
            2'd0:    return a << amt;
            2'd1:    return a >> amt;
            2'd2:    return sa >>> amt;
            default: return (a << amt) | (a >> (WIDTH - amt));
        endcase
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
            prev_stall = 1'b0;
            last_stall = cyc;
        end else begin
            check("in_ready", WIDTH'(in_ready),
                  WIDTH'(!(exp_q.size() == SHAMT_W && !out_ready)));
            if (prev_stall) begin
                check("hold_valid", WIDTH'(out_valid), WIDTH'(1));
                check("hold_data", data_result, prev_data);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: out_valid=1 data 0x%08h, required no result pending (cycle %0d)",
                             data_result, cyc);
                end else begin
                    check("result", data_result, exp_q[0]);
                    if (last_stall < acc_q[0])
                        check("latency", WIDTH'(cyc - acc_q[0]), WIDTH'(SHAMT_W));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end else if (exp_q.size() > 0 && last_stall < acc_q[0]) begin
                n_checks++;
                if (cyc - acc_q[0] >= SHAMT_W) begin
                    n_fail++;
                    $display("FAIL late_out: out_valid=0 after %0d cycles, required 1 by %0d", cyc - acc_q[0], SHAMT_W);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(data_operandA, ctrl_shiftamt, ctrl_mode));
                acc_q.push_back(cyc);
            end
            if (!out_ready) last_stall = cyc;
            prev_stall = out_valid && !out_ready;
            prev_data  = data_result;
        end
    end

    // ---------------- driver tasks (called and returning at posedge+1) ----------------
    task automatic send(input logic [WIDTH-1:0] a, input int amt, input logic [1:0] mode);
        int guard = 0;
        in_valid      = 1'b1;
        data_operandA = a;
        ctrl_shiftamt = SHAMT_W'(amt);
        ctrl_mode     = mode;
        @(negedge clock);
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0 for 100 cycles, required 1");
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [WIDTH-1:0] exp, output int waited);
        logic found = 1'b0;
        waited = 0;
        while (!found && waited < 40) begin
            @(negedge clock);
            waited++;
            if (out_valid) begin
                found = 1'b1;
                check(name, data_result, exp);
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: out_valid=0 for 40 cycles, required a result", name);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clock);
        while ((exp_q.size() != 0 || out_valid) && guard < 60) begin
            @(negedge clock);
            guard++;
        end
        check("drain_pending", WIDTH'(exp_q.size()), '0);
        @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_out_valid", WIDTH'(out_valid), '0);
        check("reset_data", data_result, '0);
        check("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
        @(posedge clock);
        #1;

        // Single ops with literal results and latency
        send(32'h0000_0001, 31, 2'd0);
        wait_result("t1_sll31", 32'h8000_0000, w);
        check("t1_latency", WIDTH'(w), WIDTH'(SHAMT_W));
        send(32'h8000_0F00, 8, 2'd2);
        wait_result("t2_sra8", 32'hFF80_000F, w);
        send(32'h8000_0F00, 8, 2'd1);
        wait_result("t2_srl8", 32'h0080_000F, w);
        send(32'h8000_0001, 1, 2'd3);
        wait_result("t2_rotl1", 32'h0000_0003, w);
        send(32'h8000_0001, 31, 2'd3);
        wait_result("t2_rotl31", 32'hC000_0000, w);

        // Back-to-back stream
        for (int i = 0; i < 8; i++) send(WIDTH'(i), i, 2'd0);
        drain();

        // Backpressure: fill, hold, release with a simultaneous accept
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) send(32'hF000_0000, j + 4, 2'd1);
        in_valid      = 1'b1;
        data_operandA = 32'h0000_00FF;
        ctrl_shiftamt = SHAMT_W'(2);
        ctrl_mode     = 2'd0;
        repeat (3) begin
            @(negedge clock);
            check("t4_in_ready_low", WIDTH'(in_ready), '0);
        end
        check("t4_head_valid", WIDTH'(out_valid), WIDTH'(1));
        check("t4_head_data", data_result, 32'h0F00_0000);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        check("t4_in_ready_release", WIDTH'(in_ready), WIDTH'(1));
        @(posedge clock);
        #1;
        drain();

        // Reset with operands in flight
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) send(32'h1234_5678, j + 1, 2'd3);
        repeat (5) @(posedge clock);
        #2;
        check("t5_valid_before_reset", WIDTH'(out_valid), WIDTH'(1));
        reset = 1'b1;
        #1;
        check("t5_async_out_valid", WIDTH'(out_valid), '0);
        check("t5_async_in_ready", WIDTH'(in_ready), WIDTH'(1));
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("t5_no_stale", WIDTH'(out_valid), '0);
        end
        @(posedge clock);
        #1;

        // Zero shift in every mode
        for (int m = 0; m < 4; m++) begin
            send(32'hDEAD_BEEF, 0, 2'(m));
            wait_result("t6_amt0", 32'hDEAD_BEEF, w);
        end

        // Random traffic with random backpressure
        repeat (400) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            data_operandA = $urandom;
            ctrl_shiftamt = SHAMT_W'($urandom_range(0, WIDTH - 1));
            ctrl_mode     = 2'($urandom_range(0, 3));
            out_ready     = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
